// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: datapath widths and the decoder control bundle.
package rv32i_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  typedef struct packed {
    logic       load;
    logic       store;
    logic       branch;
    logic       reg_write;
    logic       mem_en;
    logic       operand_a;
    logic       operand_b;
    logic       next_sel;
    logic [1:0] mem_to_reg;
    logic [3:0] alu_control;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard: the instruction in ID reads the register a load in EX writes.
module load_use_detect #(
  parameter int unsigned REG_AW = 5
) (
  input  logic              id_valid,
  input  logic              ex_valid,
  input  logic              ex_load,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  output logic              lu_hazard
);

  logic rs1_match, rs2_match;

  assign rs1_match = id_uses_rs1 && (id_rs1 == ex_rd);
  assign rs2_match = id_uses_rs2 && (id_rs2 == ex_rd);

  // x0 is never really written, so a load to it cannot create a dependency.
  assign lu_hazard = id_valid && ex_valid && ex_load && (ex_rd != '0) && (rs1_match || rs2_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, redirect flush and hold.
// Optional perf counters (stall_cnt, flush_cnt) when RV32I_PERF_CNT_EN is defined.
module id_ex_stage
  import rv32i_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [2:0]        id_fun3,
  input  logic              id_load,
  input  logic              id_store,
  input  logic              id_branch,
  input  logic              id_reg_write,
  input  logic              id_mem_en,
  input  logic              id_operand_a,
  input  logic              id_operand_b,
  input  logic              id_next_sel,
  input  logic [1:0]        id_mem_to_reg,
  input  logic [3:0]        id_alu_control,
  input  logic              ex_redirect,
  input  logic              ex_hold,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [XLEN-1:0]   ex_imm,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic [REG_AW-1:0] ex_rd,
  output logic [2:0]        ex_fun3,
  output logic              ex_load,
  output logic              ex_store,
  output logic              ex_branch,
  output logic              ex_reg_write,
  output logic              ex_mem_en,
  output logic              ex_operand_a,
  output logic              ex_operand_b,
  output logic              ex_next_sel,
  output logic [1:0]        ex_mem_to_reg,
  output logic [3:0]        ex_alu_control,
  output logic              stall_if,
  output logic              flush_id
`ifdef RV32I_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  ctrl_t id_ctrl, ctrl_d, ctrl_q;
  logic  valid_d, valid_q;
  logic  lu_hazard;

  assign id_ctrl = '{load: id_load, store: id_store, branch: id_branch,
                     reg_write: id_reg_write, mem_en: id_mem_en, operand_a: id_operand_a,
                     operand_b: id_operand_b, next_sel: id_next_sel,
                     mem_to_reg: id_mem_to_reg, alu_control: id_alu_control};

  load_use_detect #(
    .REG_AW(REG_AW)
  ) u_load_use_detect (
    .id_valid   (id_valid),
    .ex_valid   (valid_q),
    .ex_load    (ctrl_q.load),
    .ex_rd      (ex_rd),
    .id_uses_rs1(id_uses_rs1),
    .id_uses_rs2(id_uses_rs2),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .lu_hazard  (lu_hazard)
  );

  // Redirect outranks the hazard: the stalled instruction is being squashed anyway.
  assign stall_if = !rst && (ex_hold || (lu_hazard && !ex_redirect));
  assign flush_id = !rst && !ex_hold && ex_redirect;

  always_comb begin
    valid_d = 1'b0;
    ctrl_d  = CTRL_NOP;
    if (!ex_redirect && !lu_hazard && id_valid) begin
      valid_d = 1'b1;
      ctrl_d  = id_ctrl;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= 1'b0;
      ctrl_q      <= CTRL_NOP;
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_fun3     <= '0;
    end else if (!ex_hold) begin
      valid_q     <= valid_d;
      ctrl_q      <= ctrl_d;
      ex_pc       <= id_pc;
      ex_rs1_data <= id_rs1_data;
      ex_rs2_data <= id_rs2_data;
      ex_imm      <= id_imm;
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ex_rd       <= id_rd;
      ex_fun3     <= id_fun3;
    end
  end

  assign ex_valid       = valid_q;
  assign ex_load        = ctrl_q.load;
  assign ex_store       = ctrl_q.store;
  assign ex_branch      = ctrl_q.branch;
  assign ex_reg_write   = ctrl_q.reg_write;
  assign ex_mem_en      = ctrl_q.mem_en;
  assign ex_operand_a   = ctrl_q.operand_a;
  assign ex_operand_b   = ctrl_q.operand_b;
  assign ex_next_sel    = ctrl_q.next_sel;
  assign ex_mem_to_reg  = ctrl_q.mem_to_reg;
  assign ex_alu_control = ctrl_q.alu_control;

`ifdef RV32I_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (!ex_hold) begin
      if (ex_redirect) begin
        if (flush_cnt_q != 32'hFFFF_FFFF) flush_cnt_q <= flush_cnt_q + 32'd1;
      end else if (lu_hazard) begin
        if (stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; counter checks only with RV32I_PERF_CNT_EN.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_uses_rs1, id_uses_rs2;
  logic [2:0]  id_fun3;
  logic        id_load, id_store, id_branch, id_reg_write, id_mem_en;
  logic        id_operand_a, id_operand_b, id_next_sel;
  logic [1:0]  id_mem_to_reg;
  logic [3:0]  id_alu_control;
  logic        ex_redirect, ex_hold;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [2:0]  ex_fun3;
  logic        ex_load, ex_store, ex_branch, ex_reg_write, ex_mem_en;
  logic        ex_operand_a, ex_operand_b, ex_next_sel;
  logic [1:0]  ex_mem_to_reg;
  logic [3:0]  ex_alu_control;
  logic        stall_if, flush_id;
`ifdef RV32I_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  always #5 clk = ~clk;

  id_ex_stage #(
    .XLEN  (32),
    .REG_AW(5)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .id_valid      (id_valid),
    .id_pc         (id_pc),
    .id_rs1_data   (id_rs1_data),
    .id_rs2_data   (id_rs2_data),
    .id_imm        (id_imm),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_rd         (id_rd),
    .id_uses_rs1   (id_uses_rs1),
    .id_uses_rs2   (id_uses_rs2),
    .id_fun3       (id_fun3),
    .id_load       (id_load),
    .id_store      (id_store),
    .id_branch     (id_branch),
    .id_reg_write  (id_reg_write),
    .id_mem_en     (id_mem_en),
    .id_operand_a  (id_operand_a),
    .id_operand_b  (id_operand_b),
    .id_next_sel   (id_next_sel),
    .id_mem_to_reg (id_mem_to_reg),
    .id_alu_control(id_alu_control),
    .ex_redirect   (ex_redirect),
    .ex_hold       (ex_hold),
    .ex_valid      (ex_valid),
    .ex_pc         (ex_pc),
    .ex_rs1_data   (ex_rs1_data),
    .ex_rs2_data   (ex_rs2_data),
    .ex_imm        (ex_imm),
    .ex_rs1        (ex_rs1),
    .ex_rs2        (ex_rs2),
    .ex_rd         (ex_rd),
    .ex_fun3       (ex_fun3),
    .ex_load       (ex_load),
    .ex_store      (ex_store),
    .ex_branch     (ex_branch),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_en     (ex_mem_en),
    .ex_operand_a  (ex_operand_a),
    .ex_operand_b  (ex_operand_b),
    .ex_next_sel   (ex_next_sel),
    .ex_mem_to_reg (ex_mem_to_reg),
    .ex_alu_control(ex_alu_control),
    .stall_if      (stall_if),
    .flush_id      (flush_id)
`ifdef RV32I_PERF_CNT_EN
    ,
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd, input logic u1,
                       input logic u2, input logic [31:0] imm, input logic [2:0] f3,
                       input logic ld, input logic st, input logic br, input logic rw,
                       input logic [1:0] m2r, input logic [3:0] alu);
    id_valid       = v;
    id_pc          = pc;
    id_rs1         = rs1;
    id_rs2         = rs2;
    id_rd          = rd;
    id_uses_rs1    = u1;
    id_uses_rs2    = u2;
    id_imm         = imm;
    id_rs1_data    = pc + 32'd1;
    id_rs2_data    = pc + 32'd2;
    id_fun3        = f3;
    id_load        = ld;
    id_store       = st;
    id_branch      = br;
    id_reg_write   = rw;
    id_mem_en      = ld | st;
    id_operand_a   = 1'b0;
    id_operand_b   = !u2 | st;
    id_next_sel    = br;
    id_mem_to_reg  = m2r;
    id_alu_control = alu;
  endtask

  initial begin
    rst         = 1'b1;
    ex_redirect = 1'b0;
    ex_hold     = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0,
          2'd0, 4'd0);
    #1;
    check_eq("reset_ex_valid", 32'(ex_valid), 32'd0);
    check_eq("reset_stall_if", 32'(stall_if), 32'd0);
    check_eq("reset_ex_pc", ex_pc, 32'd0);
    step();
    step();
    rst = 1'b0;

    // addi x5,x0,7
    drive(1'b1, 32'h100, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 32'd7, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1,
          2'd0, 4'b0000);
    #1;
    check_eq("addi_stall_if", 32'(stall_if), 32'd0);
    step();
    check_eq("addi_ex_valid", 32'(ex_valid), 32'd1);
    check_eq("addi_ex_rd", 32'(ex_rd), 32'd5);
    check_eq("addi_ex_imm", ex_imm, 32'd7);
    check_eq("addi_ex_reg_write", 32'(ex_reg_write), 32'd1);
    check_eq("addi_ex_pc", ex_pc, 32'h100);

    // lw x3,0(x1) then add x4,x3,x2
    drive(1'b1, 32'h104, 5'd1, 5'd0, 5'd3, 1'b1, 1'b0, 32'd0, 3'b010, 1'b1, 1'b0, 1'b0, 1'b1,
          2'd1, 4'b0000);
    step();
    check_eq("lw_ex_load", 32'(ex_load), 32'd1);
    drive(1'b1, 32'h108, 5'd3, 5'd2, 5'd4, 1'b1, 1'b1, 32'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1,
          2'd0, 4'b0000);
    #1;
    check_eq("lu_stall_if", 32'(stall_if), 32'd1);
    check_eq("lu_flush_id", 32'(flush_id), 32'd0);
    step();
    check_eq("lu_bubble_valid", 32'(ex_valid), 32'd0);
    check_eq("lu_bubble_reg_write", 32'(ex_reg_write), 32'd0);
    check_eq("lu_bubble_mem_en", 32'(ex_mem_en), 32'd0);
    check_eq("lu_bubble_m2r", 32'(ex_mem_to_reg), 32'd0);
    check_eq("lu_after_stall_if", 32'(stall_if), 32'd0);
    step();
    check_eq("lu_add_valid", 32'(ex_valid), 32'd1);
    check_eq("lu_add_rd", 32'(ex_rd), 32'd4);
    check_eq("lu_add_pc", ex_pc, 32'h108);
`ifdef RV32I_PERF_CNT_EN
    check_eq("lu_stall_cnt", stall_cnt, 32'd1);
`endif

    // lw x0 then add x4,x0,x2: no dependency through x0
    drive(1'b1, 32'h10c, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 32'd0, 3'b010, 1'b1, 1'b0, 1'b0, 1'b1,
          2'd1, 4'b0000);
    step();
    drive(1'b1, 32'h110, 5'd0, 5'd2, 5'd4, 1'b1, 1'b1, 32'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1,
          2'd0, 4'b0000);
    #1;
    check_eq("x0_stall_if", 32'(stall_if), 32'd0);
    step();
    check_eq("x0_add_valid", 32'(ex_valid), 32'd1);
    check_eq("x0_add_pc", ex_pc, 32'h110);

    // lw x6 then sw x6 as store data
    drive(1'b1, 32'h114, 5'd1, 5'd0, 5'd6, 1'b1, 1'b0, 32'd0, 3'b010, 1'b1, 1'b0, 1'b0, 1'b1,
          2'd1, 4'b0000);
    step();
    drive(1'b1, 32'h118, 5'd1, 5'd6, 5'd0, 1'b1, 1'b1, 32'd4, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0,
          2'd0, 4'b0000);
    #1;
    check_eq("sw_stall_if", 32'(stall_if), 32'd1);
    step();
    check_eq("sw_bubble_valid", 32'(ex_valid), 32'd0);
    step();
    check_eq("sw_ex_store", 32'(ex_store), 32'd1);
    check_eq("sw_ex_valid", 32'(ex_valid), 32'd1);

    // Redirect with a valid instruction in ID
    drive(1'b1, 32'h11c, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 32'd9, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1,
          2'd0, 4'b0000);
    ex_redirect = 1'b1;
    #1;
    check_eq("redir_flush_id", 32'(flush_id), 32'd1);
    check_eq("redir_stall_if", 32'(stall_if), 32'd0);
    step();
    ex_redirect = 1'b0;
    check_eq("redir_ex_valid", 32'(ex_valid), 32'd0);
    check_eq("redir_ex_reg_write", 32'(ex_reg_write), 32'd0);
`ifdef RV32I_PERF_CNT_EN
    check_eq("redir_flush_cnt", flush_cnt, 32'd1);
`endif

    // Redirect together with a load-use hazard
    drive(1'b1, 32'h120, 5'd1, 5'd0, 5'd3, 1'b1, 1'b0, 32'd0, 3'b010, 1'b1, 1'b0, 1'b0, 1'b1,
          2'd1, 4'b0000);
    step();
    drive(1'b1, 32'h124, 5'd3, 5'd2, 5'd4, 1'b1, 1'b1, 32'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1,
          2'd0, 4'b0000);
    ex_redirect = 1'b1;
    #1;
    check_eq("redir_lu_stall_if", 32'(stall_if), 32'd0);
    check_eq("redir_lu_flush_id", 32'(flush_id), 32'd1);
    step();
    ex_redirect = 1'b0;
    check_eq("redir_lu_ex_valid", 32'(ex_valid), 32'd0);
`ifdef RV32I_PERF_CNT_EN
    check_eq("redir_lu_flush_cnt", flush_cnt, 32'd2);
    check_eq("redir_lu_stall_cnt", stall_cnt, 32'd2);
`endif

    // Hold for three cycles with redirect pending
    drive(1'b1, 32'h200, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 32'd7, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1,
          2'd0, 4'b0000);
    step();
    drive(1'b1, 32'h204, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 32'h55, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1,
          2'd0, 4'b0001);
    ex_hold     = 1'b1;
    ex_redirect = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("hold_stall_if", 32'(stall_if), 32'd1);
      check_eq("hold_flush_id", 32'(flush_id), 32'd0);
      step();
      check_eq("hold_ex_valid", 32'(ex_valid), 32'd1);
      check_eq("hold_ex_rd", 32'(ex_rd), 32'd5);
      check_eq("hold_ex_pc", ex_pc, 32'h200);
    end
`ifdef RV32I_PERF_CNT_EN
    check_eq("hold_flush_cnt", flush_cnt, 32'd2);
`endif
    ex_hold = 1'b0;
    #1;
    check_eq("unhold_flush_id", 32'(flush_id), 32'd1);
    check_eq("unhold_stall_if", 32'(stall_if), 32'd0);
    step();
    ex_redirect = 1'b0;
    check_eq("unhold_ex_valid", 32'(ex_valid), 32'd0);
    check_eq("unhold_ex_reg_write", 32'(ex_reg_write), 32'd0);
    check_eq("unhold_ex_pc", ex_pc, 32'h204);
`ifdef RV32I_PERF_CNT_EN
    check_eq("unhold_flush_cnt", flush_cnt, 32'd3);
`endif

    // Invalid ID slot captures zero controls
    drive(1'b0, 32'h208, 5'd0, 5'd0, 5'd11, 1'b1, 1'b0, 32'd3, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1,
          2'd2, 4'b0011);
    step();
    check_eq("inv_ex_valid", 32'(ex_valid), 32'd0);
    check_eq("inv_ex_reg_write", 32'(ex_reg_write), 32'd0);
    check_eq("inv_ex_alu", 32'(ex_alu_control), 32'd0);

    // Asynchronous reset mid-stream
    drive(1'b1, 32'h20c, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 32'd7, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1,
          2'd0, 4'b0010);
    step();
    check_eq("pre_rst_ex_valid", 32'(ex_valid), 32'd1);
    ex_hold = 1'b1;
    rst     = 1'b1;
    #1;
    check_eq("rst_ex_valid", 32'(ex_valid), 32'd0);
    check_eq("rst_ex_reg_write", 32'(ex_reg_write), 32'd0);
    check_eq("rst_ex_alu", 32'(ex_alu_control), 32'd0);
    check_eq("rst_ex_imm", ex_imm, 32'd0);
    check_eq("rst_stall_if", 32'(stall_if), 32'd0);
`ifdef RV32I_PERF_CNT_EN
    check_eq("rst_stall_cnt", stall_cnt, 32'd0);
    check_eq("rst_flush_cnt", flush_cnt, 32'd0);
`endif
    step();
    rst     = 1'b0;
    ex_hold = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
